timer_ctrl_fsm: RTL

- Control sequencer for the six-digit digital_timer.
- Converts two raw push-buttons (start/stop, lap/reset) into that block's control inputs: timer_pause level, timer_reset pulse, timer_clear level.
- Also drives a lap_hold level for a downstream display latch.
- Sits between the board I/O and digital_timer, in the same sys_clk domain.

---
 rtl/timer_ctrl_pkg.sv | 23 ++
 rtl/btn_debounce.sv | 68 ++++++
 rtl/timer_ctrl_fsm.sv | 139 +++++++++++++
 3 files changed

// File: rtl/timer_ctrl_pkg.sv
// ============================================================================
// Module      : timer_ctrl_pkg
// Description : Shared types and constants for the digital_timer control
//               sequencer (FSM state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_ctrl_pkg;

    localparam int STATE_W = 2;

    // Encodings are visible on ctrl_state, so they are fixed explicitly.
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : Raw push-button conditioner: 2-flop synchroniser, stability
//               counter and registered 0->1 press pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             level_q;
    logic             level_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q;
    logic             press_d;

    // Count consecutive disagreeing samples; the level flips on the Nth one.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, debounced level, counter and press pulse registers.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;

endmodule

`default_nettype wire

// File: rtl/timer_ctrl_fsm.sv
// ============================================================================
// Module      : timer_ctrl_fsm
// Description : Control sequencer for digital_timer. Debounces the start/stop
//               and lap/reset buttons and drives timer_pause, timer_reset,
//               timer_clear and lap_hold from a four-state FSM.
//               Optional macro PAUSE_BLINK_EN: blink timer_clear while paused.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_ctrl_fsm
    import timer_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int BLINK_HALF_CYCLES = 8
) (
    input  logic               sys_clk,
    input  logic               rst,
    input  logic               btn_start_stop,
    input  logic               btn_lap_reset,
    output logic               timer_pause,
    output logic               timer_reset,
    output logic               timer_clear,
    output logic               lap_hold,
    output logic [STATE_W-1:0] ctrl_state
);

    logic   ss_level;
    logic   ss_press;
    logic   lr_level;
    logic   lr_press;
    logic   ss_evt;
    logic   lr_evt;
    state_t state_q;
    state_t state_d;
    logic   init_q;
    logic   reset_q;
    logic   reset_d;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .btn_raw   (btn_start_stop),
        .btn_level (ss_level),
        .btn_press (ss_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lr (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .btn_raw   (btn_lap_reset),
        .btn_level (lr_level),
        .btn_press (lr_press)
    );

    // A press is only honoured while its debounced level agrees it is down.
    assign ss_evt = ss_press & ss_level;
    assign lr_evt = lr_press & lr_level;

    // Next-state logic; start/stop has priority over lap/reset.
    always_comb begin
        state_d = state_q;
        reset_d = 1'b0;
        case (state_q)
            IDLE:  if (ss_evt) state_d = RUN;
            RUN:   if (ss_evt) state_d = PAUSE; else if (lr_evt) state_d = LAP;
            LAP:   if (ss_evt) state_d = PAUSE; else if (lr_evt) state_d = RUN;
            PAUSE: begin
                if (ss_evt) begin
                    state_d = RUN;
                end else if (lr_evt) begin
                    state_d = IDLE;
                    reset_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register plus the one-shot initial clear after reset release.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            init_q  <= 1'b1;
            reset_q <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b0;
            reset_q <= reset_d | init_q;
        end
    end

    assign timer_pause = (state_q == IDLE) || (state_q == PAUSE);
    assign lap_hold    = (state_q == LAP);
    assign timer_reset = reset_q;
    assign ctrl_state  = state_q;

`ifdef PAUSE_BLINK_EN
    localparam int                BLINK_W    = $clog2(BLINK_HALF_CYCLES + 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYCLES - 1);

    logic [BLINK_W-1:0] blink_cnt_q;
    logic [BLINK_W-1:0] blink_cnt_d;
    logic               clear_q;
    logic               clear_d;

    // Blink restarts dark on PAUSE entry and is forced dark on exit.
    always_comb begin
        blink_cnt_d = '0;
        clear_d     = 1'b0;
        if ((state_d == PAUSE) && (state_q == PAUSE)) begin
            if (blink_cnt_q == BLINK_LAST) begin
                clear_d = ~clear_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                clear_d     = clear_q;
            end
        end
    end

    // Blink counter and display-blank registers.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
            clear_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            clear_q     <= clear_d;
        end
    end

    assign timer_clear = clear_q;
`else
    assign timer_clear = 1'b0;
`endif

endmodule

`default_nettype wire
